// File: rtl/stein_gcd_engine_if.sv
// rtl/stein_gcd_engine_if.sv - operand/result handshake bundle for the Stein GCD engine
//
// Purpose: groups the operand port, the result port and the abort control of
// stein_gcd_engine into one interface.
// Signals:
//   in_valid / in_ready / a / b            operand pair handshake
//   abort                                   synchronous cancel
//   out_valid / out_ready / gcd /
//   zero_flag / iter_cnt                    result handshake
// Modports:
//   master : the requester (drives operands, consumes results)
//   slave  : the engine
interface stein_gcd_engine_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             abort;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] gcd;
   logic             zero_flag;
   logic [CNT_W-1:0] iter_cnt;

   modport master (
      output in_valid, a, b, abort, out_ready,
      input  in_ready, out_valid, gcd, zero_flag, iter_cnt
   );

   modport slave (
      input  in_valid, a, b, abort, out_ready,
      output in_ready, out_valid, gcd, zero_flag, iter_cnt
   );
endinterface

// File: rtl/stein_gcd_engine.sv
// rtl/stein_gcd_engine.sv - handshaked binary (Stein) GCD engine
//
// Purpose: computes gcd(a, b) of two unsigned WIDTH-bit operands with the
// binary GCD algorithm, one algorithm step per clock.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    stein_gcd_engine_if.slave:
//            in_valid/in_ready/a/b   operand pair (in_ready high only in IDLE)
//            abort                   synchronous cancel in ITER or DONE
//            out_valid/out_ready     result handshake, result held until taken
//            gcd, zero_flag, iter_cnt registered result fields
module stein_gcd_engine #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   stein_gcd_engine_if.slave    bus
);

   localparam int KW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [WIDTH-1:0] ua;
   logic [WIDTH-1:0] ub;
   logic [KW-1:0]    k;
   logic [WIDTH-1:0] gcd_q;
   logic             zero_q;
   logic [CNT_W-1:0] cnt_q;

   logic             xfer;
   logic             op_zero;
   logic             ua_even;
   logic             ub_even;

   // abort in IDLE wins over a pending operand pair
   assign xfer    = bus.in_valid && (state_q == S_IDLE) && !bus.abort;
   assign op_zero = (bus.a == '0) || (bus.b == '0);
   assign ua_even = ~ua[0];
   assign ub_even = ~ub[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (xfer) begin
               state_d = op_zero ? S_DONE : S_ITER;
            end
         end
         S_ITER: begin
            if (bus.abort) begin
               state_d = S_IDLE;
            end else if (ua == ub) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.abort || bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath. The iteration counter doubles as the iter_cnt output: it is
   // cleared on transfer and frozen outside ITER, so it reads back the count
   // of the last completed (or aborted) operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ua     <= '0;
         ub     <= '0;
         k      <= '0;
         gcd_q  <= '0;
         zero_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (xfer) begin
                  ua    <= bus.a;
                  ub    <= bus.b;
                  k     <= '0;
                  cnt_q <= '0;
                  if (op_zero) begin
                     gcd_q  <= bus.a | bus.b;
                     zero_q <= (bus.a == '0) && (bus.b == '0);
                  end
               end
            end
            S_ITER: begin
               if (!bus.abort) begin
                  if (cnt_q != '1) begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
                  if (ua == ub) begin
                     // gcd <= min(a, b), so the shift back cannot overflow
                     gcd_q  <= ua << k;
                     zero_q <= 1'b0;
                  end else if (ua_even && ub_even) begin
                     ua <= ua >> 1;
                     ub <= ub >> 1;
                     k  <= k + KW'(1);
                  end else if (ua_even) begin
                     ua <= ua >> 1;
                  end else if (ub_even) begin
                     ub <= ub >> 1;
                  end else if (ua > ub) begin
                     // difference of two odd values is even; halve it at once
                     ua <= (ua - ub) >> 1;
                  end else begin
                     ub <= (ub - ua) >> 1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.gcd       = gcd_q;
   assign bus.zero_flag = zero_q;
   assign bus.iter_cnt  = cnt_q;

endmodule

// File: tb/tb_stein_gcd_engine.sv
// tb/tb_stein_gcd_engine.sv - self-checking bench for stein_gcd_engine
module tb_stein_gcd_engine;

   localparam int WIDTH = 16;
   localparam int CNT_W = 8;

   logic clk;
   logic rst_n;

   stein_gcd_engine_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   stein_gcd_engine #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests;
   int n_failed;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] exp_gcd;
      logic             exp_zero;
      int               exp_iter;
      int               exp_lat;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input longint got, input longint exp);
      n_tests++;
      if (got !== exp) begin
         n_failed++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic int ref_gcd(input int x, input int y);
      int p, q, t;
      p = x;
      q = y;
      while (q != 0) begin
         t = p % q;
         p = q;
         q = t;
      end
      return p;
   endfunction

   // Drive one operand pair and return #1 after the transfer edge.
   task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
      @(negedge clk);
      bus.a        = av;
      bus.b        = bv;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Edges counted from the transfer edge (inclusive) until out_valid shows.
   task automatic wait_done(output int lat);
      lat = 1;
      while (!bus.out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!bus.out_valid) check("done_timeout", 0, 1);
   endtask

   initial begin
      int lat;
      int ra, rb, eg, sh;
      logic [WIDTH-1:0] prev_gcd;

      n_tests  = 0;
      n_failed = 0;

      vecs[0] = '{16'd48,    16'd18, 16'd6,  1'b0, 6,  7};
      vecs[1] = '{16'd0,     16'd35, 16'd35, 1'b0, 0,  1};
      vecs[2] = '{16'd0,     16'd0,  16'd0,  1'b1, 0,  1};
      vecs[3] = '{16'd64,    16'd64, 16'd64, 1'b0, 1,  2};
      vecs[4] = '{16'd65535, 16'd1,  16'd1,  1'b0, 16, 17};
      vecs[5] = '{16'd21,    16'd14, 16'd7,  1'b0, 3,  4};
      vecs[6] = '{16'd100,   16'd75, 16'd25, 1'b0, 4,  5};
      vecs[7] = '{16'd35,    16'd0,  16'd35, 1'b0, 0,  1};
      vecs[8] = '{16'd7,     16'd5,  16'd1,  1'b0, 4,  5};

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.abort     = 1'b0;
      bus.out_ready = 1'b1;

      #12;
      check("rst_in_ready",  bus.in_ready,  1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_gcd",       bus.gcd,       0);
      check("rst_zero_flag", bus.zero_flag, 0);
      check("rst_iter_cnt",  bus.iter_cnt,  0);
      @(negedge clk);
      rst_n = 1'b1;

      // table-driven vectors
      foreach (vecs[i]) begin
         start_op(vecs[i].a, vecs[i].b);
         wait_done(lat);
         check($sformatf("vec%0d_gcd", i),  bus.gcd,       vecs[i].exp_gcd);
         check($sformatf("vec%0d_zero", i), bus.zero_flag, vecs[i].exp_zero);
         check($sformatf("vec%0d_iter", i), bus.iter_cnt,  vecs[i].exp_iter);
         check($sformatf("vec%0d_lat", i),  lat,           vecs[i].exp_lat);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_release", i), {bus.out_valid, bus.in_ready}, 2'b01);
      end

      // backpressure: result held, operand pulses ignored
      bus.out_ready = 1'b0;
      start_op(16'd48, 16'd18);
      wait_done(lat);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         bus.in_valid = c[0];
         bus.a        = 16'd9;
         bus.b        = 16'd3;
         @(posedge clk);
         #1;
         check("bp_hold", {bus.out_valid, bus.in_ready, bus.gcd}, {1'b1, 1'b0, 16'd6});
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release", {bus.out_valid, bus.in_ready}, 2'b01);
      @(posedge clk);
      #1;
      check("bp_no_stale_xfer", {bus.out_valid, bus.in_ready}, 2'b01);

      // abort on the third ITER cycle
      prev_gcd = bus.gcd;
      start_op(16'd48, 16'd18);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      bus.abort = 1'b1;
      @(posedge clk);
      #1;
      bus.abort = 1'b0;
      check("abort_idle", {bus.out_valid, bus.in_ready}, 2'b01);
      check("abort_gcd_kept", bus.gcd, prev_gcd);
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         check("abort_no_result", bus.out_valid, 0);
      end
      start_op(16'd21, 16'd14);
      wait_done(lat);
      check("after_abort_gcd", bus.gcd, 7);
      @(posedge clk);
      #1;

      // abort in IDLE blocks a transfer
      @(negedge clk);
      bus.a        = 16'd9;
      bus.b        = 16'd6;
      bus.in_valid = 1'b1;
      bus.abort    = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.abort    = 1'b0;
      check("idle_abort_no_xfer", {bus.out_valid, bus.in_ready}, 2'b01);

      // asynchronous reset in the middle of ITER
      start_op(16'd48, 16'd18);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_outputs", {bus.in_ready, bus.out_valid, bus.gcd, bus.zero_flag, bus.iter_cnt},
            {1'b1, 1'b0, 16'd0, 1'b0, 8'd0});
      @(negedge clk);
      rst_n = 1'b1;
      start_op(16'd100, 16'd75);
      wait_done(lat);
      check("after_arst_gcd", bus.gcd, 25);
      @(posedge clk);
      #1;

      // randomized operands against the arithmetic reference
      for (int r = 0; r < 40; r++) begin
         sh = $urandom_range(0, 6);
         ra = ($urandom_range(0, 65535) >> sh) << sh;
         rb = ($urandom_range(0, 65535) >> sh) << sh;
         if (r % 10 == 3) ra = 0;
         if (r % 10 == 7) rb = $urandom_range(0, 3);
         eg = ref_gcd(ra, rb);
         start_op(ra[WIDTH-1:0], rb[WIDTH-1:0]);
         wait_done(lat);
         check($sformatf("rnd%0d_gcd(%0d,%0d)", r, ra, rb), bus.gcd, eg);
         check($sformatf("rnd%0d_zero", r), bus.zero_flag, (ra == 0 && rb == 0));
         if (ra == 0 || rb == 0) begin
            check($sformatf("rnd%0d_iter", r), bus.iter_cnt, 0);
            check($sformatf("rnd%0d_lat", r), lat, 1);
         end else begin
            check($sformatf("rnd%0d_iter_range", r),
                  (bus.iter_cnt >= 1) && (bus.iter_cnt <= 2 * WIDTH - 1), 1);
         end
         @(posedge clk);
         #1;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
      $finish;
   end

endmodule
